pipe_reg: RTL

Parametrised elastic pipeline register: a chain of DEPTH data stages, each WIDTH bits wide, with a valid/ready handshake on both sides, a synchronous flush, and bubble collapsing. It replaces the fixed 16-bit product register between multiplier pipeline stages. Back-pressure from the consumer stalls only the occupied stages, so throughput stays one word per cycle. It also allows the multiplier datapath to be retimed across more or fewer stages without rewriting glue logic.

---
 rtl/pipe_reg.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipe_reg.sv
// Elastic pipeline register: DEPTH stages of WIDTH bits with valid/ready on both sides,
// synchronous flush and bubble collapsing. Define PIPE_REG_OCC_EN to add the occ port.
module pipe_reg #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_OCC_EN
  ,
  output logic [OCC_W-1:0] occ
`endif
);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("pipe_reg: DEPTH must be at least 1");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("pipe_reg: WIDTH must be at least 1");
    end
  endgenerate

  // Handshake: a word moves across a boundary on a rising edge only when the sender's
  // valid and the receiver's ready are both 1 in that cycle; valid never waits on ready.
  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];
  logic             in_fire;
  logic             out_fire;

  // Ready ripples from the output end: an empty stage always accepts.
  always_comb begin
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !v_q[i] | rdy[i+1];
    end
  end

  assign in_ready  = rdy[0] & !flush;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = v_q[DEPTH-1] & out_ready;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

  always_comb begin
    src_v[0] = in_fire;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v_q[i-1];
      src_d[i] = d_q[i-1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
    end
    if (flush) begin
      // Flush drops every word but leaves the data registers untouched.
      v_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v_d[i] = src_v[i];
          if (src_v[i]) begin
            d_d[i] = src_d[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

`ifdef PIPE_REG_OCC_EN
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_fire && !out_fire) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (out_fire && !in_fire) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;
`endif

endmodule
